// File: rtl/mul_csa_seq.sv
// Iterative unsigned W x W multiplier: one partial product per cycle into a carry-save
// accumulator, then a single carry-propagate add. Optional early exit: MUL_CSA_EARLY_TERM_EN.
module mul_csa_seq #(
  parameter int W = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   op1,
  input  logic [W-1:0]   op2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] product,
  output logic           busy
);
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESOLVE, DONE} state_t;

  state_t         r_state, w_next;
  logic [2*W-1:0] r_mcand, r_acc_s, r_acc_c, r_product, w_pp;
  logic [W-1:0]   r_mplier;
  logic [IW-1:0]  r_idx;
  logic           w_accept, w_last;

  assign in_ready  = (r_state == IDLE) && !rst;
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state == CALC) || (r_state == RESOLVE);
  assign product   = r_product;
  assign w_accept  = in_valid && in_ready;
  assign w_pp      = r_mplier[r_idx] ? (r_mcand << r_idx) : '0;

`ifdef MUL_CSA_EARLY_TERM_EN
  // Stop once no set multiplier bits remain above the one being folded in this cycle.
  assign w_last = (r_idx == IW'(W-1)) || (((r_mplier >> r_idx) >> 1) == '0);
`else
  assign w_last = (r_idx == IW'(W-1));
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_next = CALC;
      CALC:    if (w_last) w_next = RESOLVE;
      RESOLVE: w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_acc_s   <= '0;
      r_acc_c   <= '0;
      r_idx     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        IDLE: if (w_accept) begin
          r_mcand  <= {{W{1'b0}}, op1};
          r_mplier <= op2;
          r_acc_s  <= '0;
          r_acc_c  <= '0;
          r_idx    <= '0;
        end
        CALC: begin
          // 3:2 compress; the carry bit pushed past the MSB is dropped by the shift.
          r_acc_s <= r_acc_s ^ r_acc_c ^ w_pp;
          r_acc_c <= ((r_acc_s & r_acc_c) | (r_acc_s & w_pp) | (r_acc_c & w_pp)) << 1;
          r_idx   <= r_idx + 1'b1;
        end
        RESOLVE: r_product <= r_acc_s + r_acc_c;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_csa_seq.sv
// Self-checking bench for mul_csa_seq: directed table, busy/reset corner cases, random ops.
module tb_mul_csa_seq;
  localparam int W = 32;
`ifdef MUL_CSA_EARLY_TERM_EN
  localparam bit ET = 1'b1;
`else
  localparam bit ET = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, busy;
  logic [W-1:0]  op1 = '0, op2 = '0;
  logic [63:0]   product;
  int            n_chk = 0, n_err = 0;

  mul_csa_seq #(.W(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .out_valid(out_valid), .out_ready(out_ready),
    .product(product), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          stall;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Cycles from the accept edge until out_valid is visible.
  function automatic int exp_lat(input logic [31:0] b);
    int h = 0;
    if (!ET) return W + 1;
    for (int i = 0; i < W; i++) if (b[i]) h = i;
    return h + 2;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    int t = 0;
    op1 = a; op2 = b; in_valid = 1'b1;
    while (!in_ready && t < 100) begin @(negedge clk); t++; end
    chk("accept_wait", (t < 100), 1);
    @(negedge clk);
    in_valid = 1'b0;
    op1 = $urandom; op2 = $urandom;  // latched already; bus changes must not matter
  endtask

  task automatic finish_op(input logic [63:0] exp, input int lat, input int cnt0,
                           input int stall, input string name);
    int cnt = cnt0;
    while (!out_valid && cnt < 200) begin @(negedge clk); cnt++; end
    chk({name, " latency"}, cnt, lat);
    chk({name, " product"}, product, exp);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({name, " stall valid"}, out_valid, 1);
      chk({name, " stall product"}, product, exp);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk({name, " valid drop"}, out_valid, 0);
    chk({name, " ready back"}, in_ready, 1);
    chk({name, " product hold"}, product, exp);
    out_ready = 1'b0;
  endtask

  vec_t tbl[6];

  initial begin
    logic [31:0] a, b;

    tbl[0] = '{32'd3, 32'd5, 64'd15, 0};
    tbl[1] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 2};
    tbl[2] = '{32'h12345678, 32'd0, 64'd0, 10};
    tbl[3] = '{32'd0, 32'hDEADBEEF, 64'd0, 0};
    tbl[4] = '{32'h00010000, 32'h00010000, 64'h0000000100000000, 1};
    tbl[5] = '{32'd1, 32'h80000000, 64'h0000000080000000, 0};

    // reset values while rst is held
    #12;
    chk("rst in_ready", in_ready, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst busy", busy, 0);
    chk("rst product", product, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("post-rst in_ready", in_ready, 1);
    @(negedge clk);

    foreach (tbl[i]) begin
      start_op(tbl[i].a, tbl[i].b);
      finish_op(tbl[i].exp, exp_lat(tbl[i].b), 0, tbl[i].stall, $sformatf("vec%0d", i));
    end

    // in_valid while busy is ignored
    start_op(32'h1000, 32'd3);
    op1 = 32'd7; op2 = 32'd9; in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("busy flag", busy, 1);
      chk("busy in_ready", in_ready, 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    finish_op(64'h3000, exp_lat(32'd3), 4, 0, "busy first");
    start_op(32'd7, 32'd9);
    finish_op(64'd63, exp_lat(32'd9), 0, 0, "busy second");

    // reset mid-CALC at idx 10
    start_op(32'h80000000, 32'h80000000);
    repeat (10) @(negedge clk);
    chk("abort busy", busy, 1);
    rst = 1'b1; #1;
    chk("abort in_ready", in_ready, 0);
    chk("abort busy clr", busy, 0);
    chk("abort product", product, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("abort release ready", in_ready, 1);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) chk("abort no valid", out_valid, 0);
    end
    chk("abort idle", in_ready, 1);
    start_op(32'd2, 32'd2);
    finish_op(64'd4, exp_lat(32'd2), 0, 0, "after abort");

    // random operands against plain 64-bit multiplication
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = b >> $urandom_range(0, 31);
        1: a = '0;
        2: b = 32'd1 << $urandom_range(0, 31);
        default: ;
      endcase
      start_op(a, b);
      finish_op({32'd0, a} * {32'd0, b}, exp_lat(b), 0, $urandom_range(0, 3), "rand");
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
